// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: register offsets, FSM encodings, baud divider derivation
// and the STATUS register layout.
package uart_rx_pkg;

  localparam logic [3:0] UART_RXDATA_REG = 4'h0;
  localparam logic [3:0] UART_STATUS_REG = 4'h4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  typedef struct packed {
    logic count_hi;
    logic rsvd;
    logic frame_err;
    logic overrun;
    logic full;
    logic not_empty;
  } status_t;

  function automatic int unsigned calc_baud_div(input int unsigned clkfreq, input int unsigned baud);
    return clkfreq / baud;
  endfunction

  function automatic int unsigned calc_half_div(input int unsigned clkfreq, input int unsigned baud);
    return calc_baud_div(clkfreq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial front end: 2-flop synchroniser, mid-bit sampling FSM and shift register.
// byte_valid_o/frame_err_o are combinational pulses on the mid-stop sampling cycle; no backpressure.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned HALF_DIV = 217
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] T_BIT  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] T_HALF = CNT_W'(HALF_DIV - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] t_cnt;
  logic [2:0]       b_cnt;
  logic [7:0]       shr;
  logic             bit_end;

  assign rx_s    = sync_q[1];
  assign bit_end = (t_cnt == T_BIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      t_cnt <= '0;
      b_cnt <= '0;
      shr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            t_cnt <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (t_cnt == T_HALF) begin
            t_cnt <= '0;
            b_cnt <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            t_cnt <= t_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            t_cnt <= '0;
            shr   <= {rx_s, shr[7:1]};
            if (b_cnt == 3'd7) begin
              state <= ST_STOP;
            end else begin
              b_cnt <= b_cnt + 3'd1;
            end
          end else begin
            t_cnt <= t_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so a following start edge is not missed.
          if (bit_end) begin
            t_cnt <= '0;
            state <= rx_s ? ST_IDLE : ST_RECOVER;
          end else begin
            t_cnt <= t_cnt + CNT_W'(1);
          end
        end
        ST_RECOVER: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign byte_o       = shr;
  assign byte_valid_o = (state == ST_STOP) && bit_end && rx_s;
  assign frame_err_o  = (state == ST_STOP) && bit_end && !rx_s;

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: RX core, byte FIFO, sticky flags, RXDATA/STATUS decode.
// not_empty rises the cycle after the mid-stop sample; a push into a full FIFO drops the byte and sets overrun.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKFREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic        wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        uart_rx_i
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLKFREQ, BAUD_RATE);
  localparam int unsigned HALF_DIV = calc_half_div(CLKFREQ, BAUD_RATE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    rx_byte;
  logic          rx_vld;
  logic          rx_ferr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   count_wide;
  logic          full;
  logic          not_empty;
  logic          overrun;
  logic          frame_err;

  logic [3:0]    reg_off;
  logic          pop;
  logic          push_ok;
  logic          overrun_set;
  logic          status_wr;
  status_t       status;
  logic          unused_ok;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV),
    .HALF_DIV (HALF_DIV)
  ) u_core (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .uart_rx_i    (uart_rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_vld),
    .frame_err_o  (rx_ferr)
  );

  assign reg_off    = addr_i[3:0];
  assign full       = (count == CW'(FIFO_DEPTH));
  assign not_empty  = (count != '0);
  assign count_wide = 32'(count);

  assign pop         = sel_i && !wen_i && (reg_off == UART_RXDATA_REG) && not_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign push_ok     = rx_vld && (!full || pop);
  assign overrun_set = rx_vld && full && !pop;
  assign status_wr   = sel_i && wen_i && (reg_off == UART_STATUS_REG);

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overrun   <= overrun_set || (overrun && !(status_wr && data_i[2]));
      frame_err <= rx_ferr || (frame_err && !(status_wr && data_i[3]));
    end
  end

  always_comb begin
    status           = '0;
    status.count_hi  = (FIFO_DEPTH > 8) ? count_wide[4] : 1'b0;
    status.frame_err = frame_err;
    status.overrun   = overrun;
    status.full      = full;
    status.not_empty = not_empty;
  end

  always_comb begin
    data_o = '0;
    if (sel_i) begin
      case (reg_off)
        UART_RXDATA_REG: data_o = not_empty ? {24'b0, mem[rd_ptr]} : 32'b0;
        UART_STATUS_REG: data_o = {26'b0, status};
        default:         data_o = '0;
      endcase
    end
  end

  assign unused_ok = ^{addr_i[31:4], data_i[31:4], data_i[1:0], count_wide};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=16, HALF_DIV=8, FIFO_DEPTH=4.
module tb_uart_rx;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] data_o;
  logic        line;

  int          vectors;
  int          miscompares;
  logic [31:0] rd;
  logic [31:0] popped;

  uart_rx #(
    .CLKFREQ    (16),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sel_i     (sel),
    .wen_i     (wen),
    .addr_i    (addr),
    .data_i    (wdata),
    .data_o    (data_o),
    .uart_rx_i (line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel  = 1'b1;
    wen  = 1'b0;
    addr = {28'b0, a};
    #1 d = data_o;
    @(posedge clk);
    #1 sel = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel   = 1'b1;
    wen   = 1'b1;
    addr  = {28'b0, a};
    wdata = d;
    @(posedge clk);
    #1 sel = 1'b0;
    wen   = 1'b0;
    wdata = '0;
  endtask

  task automatic check_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic send_bit(input logic v);
    line = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  // mode 0: plain frame; 1: check STATUS around the mid-stop edge; 2: pop RXDATA on that edge
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    line = stop;
    for (int i = 0; i < 16; i++) begin
      if (i == 10 && mode != 0) begin
        sel  = 1'b1;
        wen  = 1'b0;
        addr = (mode == 1) ? 32'h4 : 32'h0;
        #1;
        if (mode == 1) check("t1_status_before_stop_edge", data_o, 32'h0);
        else popped = data_o;
      end
      @(posedge clk);
      #1;
      if (i == 10 && mode != 0) begin
        if (mode == 1) check("t1_status_after_stop_edge", data_o, 32'h1);
        sel = 1'b0;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    popped      = '0;
    rst_n = 1'b0;
    sel   = 1'b0;
    wen   = 1'b0;
    addr  = '0;
    wdata = '0;
    line  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_data_o_unselected", data_o, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_read("reset_status", 4'h4, 32'h0);
    check_read("reset_rxdata_empty", 4'h0, 32'h0);

    // 1: single frame, exact not_empty timing
    send_frame(8'hA5, 1'b1, 1);
    repeat (10) @(posedge clk);
    check_read("t1_rxdata", 4'h0, 32'h0000_00A5);
    check_read("t1_status_after_pop", 4'h4, 32'h0);

    // 2: back-to-back frames
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h55, 1'b1, 0);
    repeat (10) @(posedge clk);
    check_read("t2_pop0", 4'h0, 32'h00);
    check_read("t2_pop1", 4'h0, 32'hFF);
    check_read("t2_pop2", 4'h0, 32'h55);
    check_read("t2_status", 4'h4, 32'h0);

    // 3: overrun on the fifth frame
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    send_frame(8'h33, 1'b1, 0);
    send_frame(8'h44, 1'b1, 0);
    repeat (4) @(posedge clk);
    check_read("t3_status_full", 4'h4, 32'h3);
    send_frame(8'h55, 1'b1, 0);
    repeat (4) @(posedge clk);
    check_read("t3_status_overrun", 4'h4, 32'h7);
    check_read("t3_pop0", 4'h0, 32'h11);
    check_read("t3_pop1", 4'h0, 32'h22);
    check_read("t3_pop2", 4'h0, 32'h33);
    check_read("t3_pop3", 4'h0, 32'h44);
    check_read("t3_status_drained", 4'h4, 32'h4);
    bus_write(4'h4, 32'h4);
    check_read("t3_status_cleared", 4'h4, 32'h0);

    // 4: glitch rejection, then a framing error held as a break
    line = 1'b0;
    repeat (4) @(posedge clk);
    #1 line = 1'b1;
    repeat (30) @(posedge clk);
    check_read("t4_glitch_status", 4'h4, 32'h0);
    send_frame(8'h00, 1'b0, 0);
    repeat (40) @(posedge clk);
    check_read("t4_break_status", 4'h4, 32'h8);
    #1 line = 1'b1;
    repeat (20) @(posedge clk);
    check_read("t4_after_break_status", 4'h4, 32'h8);
    send_frame(8'h3C, 1'b1, 0);
    repeat (4) @(posedge clk);
    check_read("t4_status_valid", 4'h4, 32'h9);
    check_read("t4_rxdata", 4'h0, 32'h3C);
    bus_write(4'h4, 32'h8);
    check_read("t4_status_cleared", 4'h4, 32'h0);

    // 5: push and pop on the same edge while full
    send_frame(8'h61, 1'b1, 0);
    send_frame(8'h62, 1'b1, 0);
    send_frame(8'h63, 1'b1, 0);
    send_frame(8'h64, 1'b1, 0);
    send_frame(8'h65, 1'b1, 2);
    repeat (4) @(posedge clk);
    check("t5_popped_on_stop_edge", popped, 32'h61);
    check_read("t5_status_full_no_overrun", 4'h4, 32'h3);
    check_read("t5_pop0", 4'h0, 32'h62);
    check_read("t5_pop1", 4'h0, 32'h63);
    check_read("t5_pop2", 4'h0, 32'h64);
    check_read("t5_pop3", 4'h0, 32'h65);
    check_read("t5_status_empty", 4'h4, 32'h0);

    // 6: reset mid-frame with a queued byte and a sticky flag pending
    send_frame(8'h00, 1'b0, 0);
    #1 line = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h5A, 1'b1, 0);
    repeat (4) @(posedge clk);
    check_read("t6_status_before_reset", 4'h4, 32'h9);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    line = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    sel  = 1'b1;
    wen  = 1'b0;
    addr = 32'h4;
    #1 check("t6_status_in_reset", data_o, 32'h0);
    sel = 1'b0;
    #1 check("t6_data_o_unselected", data_o, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check_read("t6_status_after_reset", 4'h4, 32'h0);
    check_read("t6_rxdata_after_reset", 4'h0, 32'h0);
    send_frame(8'h81, 1'b1, 0);
    repeat (4) @(posedge clk);
    check_read("t6_rxdata_clean_frame", 4'h0, 32'h81);
    check_read("t6_status_final", 4'h4, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
